// File: rtl/tile_step_sequencer.sv
// ---------------------------------------------------------------------------
// tile_step_sequencer
//
// Control sequencer for one tensor-core tile operation. It issues the operand
// load request, then offers N compute steps with valid/ready flow control,
// waits DRAIN_CYCLES cycles and raises a one-cycle completion pulse. An abort
// in any busy state returns to IDLE without a completion pulse.
//
// Optional feature macro: TILE_SEQ_STALL_CNT_EN
//   defined   : stall_cycles counts COMPUTE cycles with step_ready low
//               (saturating, cleared on an accepted start)
//   undefined : stall_cycles is tied to zero
//
// Ports
//   CLK          in   clock, rising edge
//   RST          in   asynchronous active-high reset
//   start        in   begin a tile (sampled in IDLE only)
//   num_steps    in   step count for the tile, saturates to MAX_STEPS
//   abort        in   cancel the operation in progress
//   load_req     out  operand load request (LOAD state)
//   load_ack     in   single-cycle load completion
//   step_valid   out  compute step offered (COMPUTE state)
//   step_ready   in   MAC array accepts the offered step
//   step_idx     out  index of the offered step, 0..N-1
//   busy         out  high in any state other than IDLE
//   done         out  one-cycle completion pulse
//   state_o      out  current state encoding
//   stall_cycles out  stall count (see macro above)
// ---------------------------------------------------------------------------
module tile_step_sequencer #(
    parameter int MAX_STEPS    = 16,
    parameter int STEP_W       = $clog2(MAX_STEPS + 1),
    parameter int DRAIN_CYCLES = 2,
    parameter int STALL_W      = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic [STEP_W-1:0]  num_steps,
    input  logic               abort,
    output logic               load_req,
    input  logic               load_ack,
    output logic               step_valid,
    input  logic               step_ready,
    output logic [STEP_W-1:0]  step_idx,
    output logic               busy,
    output logic               done,
    output logic [2:0]         state_o,
    output logic [STALL_W-1:0] stall_cycles
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [STEP_W-1:0]  STEP_MAX   = STEP_W'(MAX_STEPS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        COMPUTE = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [STEP_W-1:0]   n_reg;
    logic [STEP_W-1:0]   step_cnt;
    logic [DRAIN_W-1:0]  drain_cnt;
    logic                abort_hit;
    logic                last_step;
    logic                start_acc;

    function automatic logic [STEP_W-1:0] sat_steps(input logic [STEP_W-1:0] req);
        if (req > STEP_MAX) begin
            return STEP_MAX;
        end
        return req;
    endfunction

    // Abort is only honoured outside IDLE; in IDLE a simultaneous start wins.
    assign abort_hit = abort && (state != IDLE);
    assign last_step = (step_cnt == (n_reg - 1'b1));
    assign start_acc = (state == IDLE) && start;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = (num_steps == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (load_ack) begin
                    state_n = COMPUTE;
                end
            end
            COMPUTE: begin
                if (step_ready && last_step) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (abort_hit) begin
            state_n = IDLE;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            n_reg     <= '0;
            step_cnt  <= '0;
            drain_cnt <= '0;
        end else if (abort_hit) begin
            step_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        n_reg     <= sat_steps(num_steps);
                        step_cnt  <= '0;
                        drain_cnt <= '0;
                    end
                end
                LOAD: begin
                    if (load_ack) begin
                        step_cnt <= '0;
                    end
                end
                COMPUTE: begin
                    if (step_ready) begin
                        if (last_step) begin
                            drain_cnt <= '0;
                        end else begin
                            step_cnt <= step_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt != DRAIN_LAST) begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef TILE_SEQ_STALL_CNT_EN
    localparam logic [STALL_W-1:0] STALL_MAX = '1;
    logic [STALL_W-1:0] stall_q;

    // Holds through abort so the dispatcher can still read the partial count.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_q <= '0;
        end else if (start_acc) begin
            stall_q <= '0;
        end else if ((state == COMPUTE) && !step_ready && (stall_q != STALL_MAX)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cycles = stall_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
    assign stall_cycles     = '0;
`endif

    assign load_req   = (state == LOAD);
    assign step_valid = (state == COMPUTE);
    assign step_idx   = step_cnt;
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign state_o    = state;

endmodule

// File: tb/tb_tile_step_sequencer.sv
module tb_tile_step_sequencer;

    localparam int MAX_STEPS = 16;
    localparam int STEP_W    = 5;
    localparam int STALL_W   = 16;

    logic               CLK;
    logic               RST;
    logic               start;
    logic [STEP_W-1:0]  num_steps;
    logic               abort;
    logic               load_req;
    logic               load_ack;
    logic               step_valid;
    logic               step_ready;
    logic [STEP_W-1:0]  step_idx;
    logic               busy;
    logic               done;
    logic [2:0]         state_o;
    logic [STALL_W-1:0] stall_cycles;

    int total;
    int bad;

    tile_step_sequencer #(
        .MAX_STEPS(MAX_STEPS),
        .STEP_W(STEP_W),
        .DRAIN_CYCLES(2),
        .STALL_W(STALL_W)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .start(start),
        .num_steps(num_steps),
        .abort(abort),
        .load_req(load_req),
        .load_ack(load_ack),
        .step_valid(step_valid),
        .step_ready(step_ready),
        .step_idx(step_idx),
        .busy(busy),
        .done(done),
        .state_o(state_o),
        .stall_cycles(stall_cycles)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs driven 1 time unit after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_state"}, state_o, 0);
        check({tag, "_load_req"}, load_req, 0);
        check({tag, "_step_valid"}, step_valid, 0);
        check({tag, "_step_idx"}, step_idx, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    initial begin
        int xfers;
        int last_idx;
        int seen_done;
        int seen_req;
        int exp_stall;

        total = 0;
        bad   = 0;
`ifdef TILE_SEQ_STALL_CNT_EN
        exp_stall = 2;
`else
        exp_stall = 0;
`endif
        RST        = 1'b1;
        start      = 1'b0;
        num_steps  = '0;
        abort      = 1'b0;
        load_ack   = 1'b0;
        step_ready = 1'b0;

        // Reset state
        #3;
        check_idle_outputs("rst");
        check("rst_stall", stall_cycles, 0);
        tick();
        tick();
        RST = 1'b0;
        tick();

        // Test 1: three steps, immediate ack, ready held high
        start = 1'b1; num_steps = 5'd3;
        tick();
        check("t1_load_state", state_o, 1);
        check("t1_load_req", load_req, 1);
        check("t1_busy", busy, 1);
        start = 1'b0; load_ack = 1'b1; step_ready = 1'b1;
        tick();
        load_ack = 1'b0;
        check("t1_valid", step_valid, 1);
        check("t1_idx0", step_idx, 0);
        check("t1_req_off", load_req, 0);
        tick();
        check("t1_idx1", step_idx, 1);
        tick();
        check("t1_idx2", step_idx, 2);
        tick();
        check("t1_drain_a", state_o, 3);
        check("t1_valid_off", step_valid, 0);
        check("t1_nodone_a", done, 0);
        tick();
        check("t1_drain_b", state_o, 3);
        tick();
        check("t1_done", done, 1);
        check("t1_done_state", state_o, 4);
        tick();
        check("t1_busy_after", busy, 0);
        check("t1_done_after", done, 0);

        // Test 2: four steps, ready low for two cycles at step 1
        start = 1'b1; num_steps = 5'd4;
        tick();
        start = 1'b0; load_ack = 1'b1; step_ready = 1'b1;
        tick();
        load_ack = 1'b0;
        check("t2_idx0", step_idx, 0);
        tick();
        check("t2_idx1_a", step_idx, 1);
        step_ready = 1'b0;
        tick();
        check("t2_idx1_b", step_idx, 1);
        tick();
        check("t2_idx1_c", step_idx, 1);
        check("t2_valid_stall", step_valid, 1);
        step_ready = 1'b1;
        tick();
        check("t2_idx2", step_idx, 2);
        tick();
        check("t2_idx3", step_idx, 3);
        tick();
        check("t2_drain", state_o, 3);
        tick();
        check("t2_nodone", done, 0);
        tick();
        check("t2_done", done, 1);
        check("t2_stall", stall_cycles, exp_stall);
        tick();
        check("t2_stall_hold", stall_cycles, exp_stall);

        // Test 3: zero steps goes straight to DONE; start clears the stall count
        start = 1'b1; num_steps = 5'd0;
        tick();
        start = 1'b0;
        check("t3_done", done, 1);
        check("t3_busy", busy, 1);
        check("t3_state", state_o, 4);
        check("t3_no_req", load_req, 0);
        check("t3_no_valid", step_valid, 0);
        check("t3_stall_clr", stall_cycles, 0);
        tick();
        check("t3_idle", state_o, 0);
        check("t3_done_off", done, 0);

        // Test 4: num_steps above MAX_STEPS saturates to 16 transfers
        start = 1'b1; num_steps = 5'd20;
        tick();
        start = 1'b0; load_ack = 1'b1; step_ready = 1'b1;
        xfers = 0; last_idx = -1; seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            load_ack = 1'b0;
            if (step_valid) begin
                xfers++;
                last_idx = int'(step_idx);
            end
            if (done) begin
                seen_done = 1;
                break;
            end
        end
        check("t4_xfers", xfers, 16);
        check("t4_last_idx", last_idx, 15);
        check("t4_done_seen", seen_done, 1);
        tick();

        // Test 5: abort at step 2 of 5, then abort+start in IDLE (start wins)
        start = 1'b1; num_steps = 5'd5;
        tick();
        start = 1'b0; load_ack = 1'b1;
        tick();
        load_ack = 1'b0;
        tick();
        tick();
        check("t5_idx2", step_idx, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_abort_state", state_o, 0);
        check("t5_abort_busy", busy, 0);
        check("t5_abort_idx", step_idx, 0);
        seen_done = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) seen_done = 1;
            tick();
        end
        check("t5_no_done", seen_done, 0);
        start = 1'b1; abort = 1'b1; num_steps = 5'd1;
        tick();
        start = 1'b0; abort = 1'b0; load_ack = 1'b1;
        check("t5_restart_load", state_o, 1);
        tick();
        load_ack = 1'b0;
        check("t5_one_idx", step_idx, 0);
        tick();
        tick();
        check("t5_one_nodone", done, 0);
        tick();
        check("t5_one_done", done, 1);
        tick();

        // Test 6: asynchronous reset in DRAIN, then a fresh start begins from LOAD
        start = 1'b1; num_steps = 5'd1;
        tick();
        start = 1'b0; load_ack = 1'b1;
        tick();
        load_ack = 1'b0;
        tick();
        check("t6_in_drain", state_o, 3);
        #2;
        RST = 1'b1;
        #1;
        check_idle_outputs("t6_rst");
        check("t6_rst_stall", stall_cycles, 0);
        tick();
        RST = 1'b0;
        seen_req = 0;
        for (int i = 0; i < 3; i++) begin
            if (done || busy) seen_req = 1;
            tick();
        end
        check("t6_quiet", seen_req, 0);
        start = 1'b1; num_steps = 5'd2;
        tick();
        start = 1'b0;
        check("t6_load", state_o, 1);
        check("t6_load_req", load_req, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tile_step_sequencer.md
# tile_step_sequencer

Parametrised control sequencer for one tensor-core tile operation. Walks a fixed phase sequence: operand load handshake, a run-time-programmable number of compute steps with per-step valid/ready flow control, a fixed drain interval, then a one-cycle completion pulse. It sits between the tile dispatcher, which issues `start`, and the operand buffers and MAC array, which consume `load_req` and `step_*`. It supports abort and compile-time stall accounting.

## Interface
- `MAX_STEPS`, 16: largest programmable step count; must be ≥1.
- `STEP_W`, `$clog2(MAX_STEPS+1)`: width of step-count and index buses.
- `DRAIN_CYCLES`, 2: cycles spent in DRAIN; must be ≥1.
- `STALL_W`, 16: width of the stall counter.
- `CLK` input 1: clock; all state updates on the rising edge.
- `RST` input 1: asynchronous, active-high reset.
- `start` input 1: begin a tile; sampled only in IDLE.
- `num_steps` input STEP_W: compute steps for this tile; sampled with `start`. Values >MAX_STEPS saturate to MAX_STEPS.
- `abort` input 1: cancel the operation in progress.
- `load_req` output 1: operand load request.
- `load_ack` input 1: load complete; a single-cycle pulse.
- `step_valid` output 1: compute step offered.
- `step_ready` input 1: MAC array accepts the step.
- `step_idx` output STEP_W: index of the offered step, counting 0 to N-1.
- `busy` output 1: high in any state other than IDLE.
- `done` output 1: one-cycle completion pulse.
- `state_o` output 3: current state encoding.
- `stall_cycles` output STALL_W: stall count; see Configuration.

## Operation
- State encodings:
  - IDLE=0
  - LOAD=1
  - COMPUTE=2
  - DRAIN=3
  - DONE=4
  - Encodings 5–7 are unreachable and return to IDLE.
- IDLE:
  - On `start` with `num_steps`≠0: latch N = min(`num_steps`, MAX_STEPS) and go to LOAD.
  - On `start` with `num_steps`=0: go directly to DONE.
- LOAD:
  - `load_req`=1.
  - On `load_ack`: clear step counter, go to COMPUTE.
- COMPUTE:
  - `step_valid`=1 and `step_idx`=counter.
  - A step transfers when `step_valid` && `step_ready`.
  - On transfer with counter=N-1: clear the drain counter and go to DRAIN.
  - On any other transfer: increment the counter.
- DRAIN: count DRAIN_CYCLES cycles, then go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `abort`:
  - In any non-IDLE state, the next state is IDLE and all counters clear.
  - No `done` pulse is produced.
  - Abort takes priority over every other transition.
  - `abort` in IDLE is ignored.
  - `abort` and `start` together in IDLE: `start` wins.
- `start` is ignored in every state except IDLE.
- `load_ack` outside LOAD is ignored.
- `step_ready` outside COMPUTE is ignored.
- Outputs are decoded from state only (Moore), except `step_idx`, which follows the registered counter.

## Timing
- Reset values:
  - state=IDLE
  - `load_req`=0, `step_valid`=0, `step_idx`=0
  - `busy`=0, `done`=0, `state_o`=0, `stall_cycles`=0
  - Internal N and all counters cleared.
- Reset mid-operation returns to IDLE immediately (asynchronous). No `done` is produced.
- `start` sampled at edge t: `load_req` and `busy` are high in cycle t+1.
- With `load_ack` in the first LOAD cycle and `step_ready` held high, `done` is high in cycle t+2+N+DRAIN_CYCLES.
- Each cycle with `step_ready`=0 in COMPUTE adds one cycle of latency.
- A zero-step start produces `done` in cycle t+1, with `busy`=1 for that cycle.
- `done` cycle → IDLE: a new `start` is accepted in the cycle after `done`.

## Configuration
- `TILE_SEQ_STALL_CNT_EN`:
  - Defined:
    - `stall_cycles` increments in each COMPUTE cycle with `step_ready`=0.
    - It saturates at 2^STALL_W-1.
    - It clears when an accepted `start` is sampled.
    - It holds its value otherwise, including through abort.
  - Undefined:
    - `stall_cycles` is tied to 0 and no counter logic is synthesised.
    - The port remains present.

## Test plan
- Reset, then drive `start`=1 with `num_steps`=3 and ACK immediately, `step_ready`=1 → `step_idx` 0,1,2 on consecutive cycles; `done` 7 cycles after the `start` edge; `busy` low the cycle after.
- `num_steps`=4 with `step_ready` low for 2 cycles at step 1 → `step_idx` holds at 1 for 3 cycles; `done` delayed by 2 cycles; `stall_cycles`=2 with the macro defined, 0 without.
- `num_steps`=0 → `done` 1 cycle after `start`; `load_req` and `step_valid` never assert.
- `num_steps`=20 (MAX_STEPS=16) → exactly 16 step transfers; last `step_idx`=15.
- `abort` asserted at `step_idx`=2 of 5 → IDLE next cycle, no `done`; then `start` with `num_steps`=1 completes normally.
- Assert `RST` during DRAIN → all outputs return to their reset values immediately; a `start` after `RST` deasserts begins from LOAD.
